// File: rtl/joy_pkg.sv
// Shared joystick definitions: reader FSM states, frame geometry and the
// button bit positions used by the DB15/DB9 readers and the top-level mapping.
package joy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } joy_state_e;

    localparam int unsigned JOY_FRAME_BITS = 32;
    localparam int unsigned JOY_WORD_BITS  = 16;

    localparam int unsigned JOY_R      = 0;
    localparam int unsigned JOY_L      = 1;
    localparam int unsigned JOY_D      = 2;
    localparam int unsigned JOY_U      = 3;
    localparam int unsigned JOY_A      = 4;
    localparam int unsigned JOY_B      = 5;
    localparam int unsigned JOY_C      = 6;
    localparam int unsigned JOY_DD     = 7;
    localparam int unsigned JOY_E      = 8;
    localparam int unsigned JOY_F      = 9;
    localparam int unsigned JOY_START  = 10;
    localparam int unsigned JOY_SELECT = 11;

endpackage

// File: rtl/joy_tick_gen.sv
// Half-period divider for the 74HC165 shift clock. One count cycle is
// 2*HALF_DIV clk cycles: the first half is the low phase, the second the high.
module joy_tick_gen #(
    parameter int unsigned HALF_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic phase,
    output logic phase_end
);

    localparam int unsigned CNT_W = $clog2(2 * HALF_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HALF_DIV);

    logic [CNT_W-1:0] cnt;

    // Divider counter: cleared by the FSM, wraps explicitly at the end of a full period
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign phase     = (cnt >= CNT_HIGH);
    assign phase_end = (cnt == CNT_MID) || (cnt == CNT_LAST);

endmodule

// File: rtl/db15_serial_reader.sv
// DB15 adapter reader: polls the 74HC165 chain, shifts in 32 active-low
// button bits and presents two optionally two-frame-filtered player words.
module db15_serial_reader
    import joy_pkg::*;
#(
    parameter int unsigned HALF_DIV    = 8,
    parameter int unsigned POLL_CYCLES = 50000,
    parameter bit          FILTER      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     JOY_DATA,
    output logic                     JOY_CLK,
    output logic                     JOY_LOAD,
    output logic [JOY_WORD_BITS-1:0] joystick1,
    output logic [JOY_WORD_BITS-1:0] joystick2,
    output logic                     frame_done,
    output logic                     glitch
);

    localparam int unsigned      POLL_W      = $clog2(POLL_CYCLES + 1);
    localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYCLES - 1);
    localparam logic [4:0]        LAST_BIT    = 5'(JOY_FRAME_BITS - 1);

    joy_state_e                state, state_next;
    logic [POLL_W-1:0]         poll_cnt;
    logic [4:0]                bit_idx;
    logic [JOY_FRAME_BITS-1:0] frame;
    logic [JOY_FRAME_BITS-1:0] prev;
    logic                      phase, phase_end;
    logic                      tick_clear, tick_en;
    logic                      poll_expired, low_end, high_end;
    logic                      joy_clk_next, commit_ok;

    joy_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clear     (tick_clear),
        .enable    (tick_en),
        .phase     (phase),
        .phase_end (phase_end)
    );

    // Next-state and next-output decode; JOY_CLK/JOY_LOAD are registered from the next state
    always_comb begin
        state_next   = state;
        poll_expired = (poll_cnt == '0);
        tick_clear   = (state == IDLE) && poll_expired;
        tick_en      = (state == LOAD) || (state == SHIFT);
        low_end      = phase_end && !phase;
        high_end     = phase_end && phase;
        commit_ok    = !FILTER || (frame == prev);
        case (state)
            IDLE:    if (poll_expired) state_next = LOAD;
            LOAD:    if (high_end) state_next = SHIFT;
            SHIFT:   if (high_end && (bit_idx == LAST_BIT)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // the phase flips after its last cycle, so the next-cycle phase is phase^phase_end
        joy_clk_next = (state_next == SHIFT) && (phase ^ phase_end);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Poll counter, shift register, frame compare and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt   <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            prev       <= '0;
            joystick1  <= '0;
            joystick2  <= '0;
            frame_done <= 1'b0;
            glitch     <= 1'b0;
            JOY_CLK    <= 1'b0;
            JOY_LOAD   <= 1'b1;
        end else begin
            JOY_CLK    <= joy_clk_next;
            JOY_LOAD   <= (state_next != LOAD);
            frame_done <= 1'b0;
            glitch     <= 1'b0;

            if (state == COMMIT) begin
                poll_cnt <= POLL_RELOAD;
            end else if ((state == IDLE) && !poll_expired) begin
                poll_cnt <= poll_cnt - 1'b1;
            end

            if (state == LOAD) begin
                bit_idx <= '0;
            end else if ((state == SHIFT) && high_end) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if ((state == SHIFT) && low_end) begin
                frame[bit_idx] <= ~JOY_DATA;
            end

            if (state == COMMIT) begin
                prev <= frame;
                if (commit_ok) begin
                    joystick1  <= frame[JOY_WORD_BITS-1:0];
                    joystick2  <= frame[JOY_FRAME_BITS-1:JOY_WORD_BITS];
                    frame_done <= 1'b1;
                end else begin
                    glitch <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_db15_serial_reader.sv
// Bench for db15_serial_reader: three instances (filtered, unfiltered, fast
// divider) each driven by a behavioural 32-bit 74HC165 chain whose serial
// output is only valid on the last low-phase cycle before each rising edge.
module tb_db15_serial_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] btn [3];
    logic        force_low [3];
    logic        jd [3], jc [3], jl [3], fd [3], gl [3];
    logic [15:0] j1 [3], j2 [3];

    logic [31:0] m_prev [3];
    logic [31:0] m_out  [3];
    bit          m_filt [3];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Parallel-input vector producing the wanted active-high frame: bit k leaves Q7 k-th, low = pressed
    function automatic logic [31:0] par_of(input logic [31:0] f);
        logic [31:0] p;
        for (int i = 0; i < 32; i++) p[31-i] = ~f[i];
        return p;
    endfunction

    // Chain models, one per instance
    for (genvar g = 0; g < 3; g++) begin : g_chain
        localparam int unsigned H = (g == 2) ? 2 : 8;
        logic [31:0] sreg    = '1;
        int unsigned low_run = 0;

        // PL low loads the buttons, CP rising shifts toward Q7 with the serial input pulled high
        always @(posedge jc[g] or negedge jl[g]) begin
            if (!jl[g]) sreg <= par_of(btn[g]);
            else        sreg <= {sreg[30:0], 1'b1};
        end

        // Count consecutive shift-clock low cycles since the last high phase or load
        always @(posedge clk) begin
            low_run <= (jc[g] || !jl[g]) ? 0 : low_run + 1;
        end

        assign jd[g] = force_low[g] ? 1'b0 : ((low_run == H - 1) ? sreg[31] : ~sreg[31]);
    end

    db15_serial_reader #(.HALF_DIV(8), .POLL_CYCLES(20), .FILTER(1'b1)) u_dut_f1 (
        .clk(clk), .reset(reset), .JOY_DATA(jd[0]), .JOY_CLK(jc[0]), .JOY_LOAD(jl[0]),
        .joystick1(j1[0]), .joystick2(j2[0]), .frame_done(fd[0]), .glitch(gl[0]));

    db15_serial_reader #(.HALF_DIV(8), .POLL_CYCLES(20), .FILTER(1'b0)) u_dut_f0 (
        .clk(clk), .reset(reset), .JOY_DATA(jd[1]), .JOY_CLK(jc[1]), .JOY_LOAD(jl[1]),
        .joystick1(j1[1]), .joystick2(j2[1]), .frame_done(fd[1]), .glitch(gl[1]));

    db15_serial_reader #(.HALF_DIV(2), .POLL_CYCLES(1), .FILTER(1'b1)) u_dut_fast (
        .clk(clk), .reset(reset), .JOY_DATA(jd[2]), .JOY_CLK(jc[2]), .JOY_LOAD(jl[2]),
        .joystick1(j1[2]), .joystick2(j2[2]), .frame_done(fd[2]), .glitch(gl[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int d = 0; d < 3; d++) begin
            m_prev[d] = '0;
            m_out[d]  = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_load_%0d", d), 32'(jl[d]), 32'd1);
            check($sformatf("rst_clk_%0d", d),  32'(jc[d]), 32'd0);
            check($sformatf("rst_done_%0d", d), 32'(fd[d]), 32'd0);
            check($sformatf("rst_gl_%0d", d),   32'(gl[d]), 32'd0);
            check($sformatf("rst_j1_%0d", d),   32'(j1[d]), 32'd0);
            check($sformatf("rst_j2_%0d", d),   32'(j2[d]), 32'd0);
        end
        reset = 1'b0;
        clear_models();
    endtask

    // Wait (bounded) for the next frame_done or glitch pulse of instance d
    task automatic wait_commit(input int d, output int cycles, output bit dn, output bit gt);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        dn     = 1'b0;
        gt     = 1'b0;
        for (int c = 1; c <= 2000 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (fd[d] || gl[d]) begin
                seen   = 1'b1;
                cycles = c;
                dn     = fd[d];
                gt     = gl[d];
            end
        end
        check($sformatf("event_seen_%0d", d), 32'(seen), 32'd1);
    endtask

    // Reference rule: commit when unfiltered or the frame repeats, otherwise flag a glitch
    task automatic model_check(input int d, input logic [31:0] eff, input bit dn, input bit gt,
                               input string tag);
        bit exp_done;
        exp_done = !m_filt[d] || (eff == m_prev[d]);
        if (exp_done) m_out[d] = eff;
        m_prev[d] = eff;
        check($sformatf("%s_done", tag),   32'(dn), 32'(exp_done));
        check($sformatf("%s_glitch", tag), 32'(gt), 32'(!exp_done));
        check($sformatf("%s_j1", tag),     32'(j1[d]), 32'(m_out[d][15:0]));
        check($sformatf("%s_j2", tag),     32'(j2[d]), 32'(m_out[d][31:16]));
    endtask

    task automatic run_frame(input int d, input logic [31:0] f, input bit frc, input string tag,
                             output int cycles);
        bit dn, gt;
        btn[d]       = f;
        force_low[d] = frc;
        wait_commit(d, cycles, dn, gt);
        model_check(d, frc ? 32'hFFFF_FFFF : f, dn, gt, tag);
    endtask

    int          cyc, first_low, load_cnt, rises, bad_runs, run_len, done_cyc, glitches;
    bit          prev_clk, dn, gt, finished;
    logic [31:0] base, pat, rnd;

    initial begin
        m_filt = '{1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 3; d++) begin
            btn[d]       = '0;
            force_low[d] = 1'b0;
        end
        do_reset();

        // 1: released adapter, frame timing after reset
        first_low = 0; load_cnt = 0; rises = 0; bad_runs = 0; run_len = 0;
        done_cyc = 0; glitches = 0; prev_clk = 1'b0; finished = 1'b0;
        for (int c = 1; c <= 700 && !finished; c++) begin
            @(posedge clk);
            #1;
            if (!jl[0]) begin
                if (load_cnt == 0) first_low = c;
                load_cnt++;
            end
            if (jc[0]) begin
                if (!prev_clk) rises++;
                run_len++;
            end else if (prev_clk) begin
                if (run_len != 8) bad_runs++;
                run_len = 0;
            end
            prev_clk = jc[0];
            if (gl[0]) glitches++;
            if (fd[0]) begin
                done_cyc = c;
                finished = 1'b1;
            end
        end
        check("t1_load_start", 32'(first_low), 32'd1);
        check("t1_load_len",   32'(load_cnt),  32'd16);
        check("t1_clk_pulses", 32'(rises),     32'd32);
        check("t1_high_runs",  32'(bad_runs),  32'd0);
        check("t1_done_cycle", 32'(done_cyc),  32'd530);
        check("t1_glitches",   32'(glitches),  32'd0);
        check("t1_j1",         32'(j1[0]),     32'd0);
        check("t1_j2",         32'(j2[0]),     32'd0);
        @(posedge clk);
        #1;
        check("t1_done_width", 32'(fd[0]), 32'd0);

        // 2: P1 Up+Start, P2 Fire A needs two identical frames
        base = {16'h0010, 16'h0408};
        run_frame(0, base, 1'b0, "t2_f1", cyc);
        run_frame(0, base, 1'b0, "t2_f2", cyc);
        check("t2_j1_const", 32'(j1[0]), 32'h0408);
        check("t2_j2_const", 32'(j2[0]), 32'h0010);

        // 3: toggle P1 A on alternate frames, then hold it
        for (int i = 0; i < 4; i++)
            run_frame(0, base ^ ((i % 2 == 0) ? 32'h10 : 32'h0), 1'b0, $sformatf("t3_tog%0d", i), cyc);
        run_frame(0, base ^ 32'h10, 1'b0, "t3_hold1", cyc);
        run_frame(0, base ^ 32'h10, 1'b0, "t3_hold2", cyc);

        // random frames, each repeated 1..3 times
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            for (int r = 0; r < int'($urandom_range(1, 3)); r++)
                run_frame(0, rnd, 1'b0, $sformatf("rnd0_%0d_%0d", i, r), cyc);
        end

        // 5: reset during bit 20 of a frame
        do_reset();
        pat = $urandom | 32'h1;
        run_frame(0, pat, 1'b0, "t5_pre1", cyc);
        run_frame(0, pat, 1'b0, "t5_pre2", cyc);
        rises = 0; prev_clk = jc[0];
        for (int c = 0; c < 2000 && rises < 20; c++) begin
            @(posedge clk);
            #1;
            if (jc[0] && !prev_clk) rises++;
            prev_clk = jc[0];
        end
        check("t5_reached_bit20", 32'(rises), 32'd20);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_models();
        check("t5_clk",  32'(jc[0]), 32'd0);
        check("t5_load", 32'(jl[0]), 32'd1);
        check("t5_j1",   32'(j1[0]), 32'd0);
        check("t5_j2",   32'(j2[0]), 32'd0);
        check("t5_done", 32'(fd[0]), 32'd0);
        @(posedge clk);
        #1;
        check("t5_reload", 32'(jl[0]), 32'd0);
        wait_commit(0, cyc, dn, gt);
        check("t5_first_event_cycle", 32'(cyc), 32'd529);
        model_check(0, pat, dn, gt, "t5_after");

        // 4: unfiltered instance commits every frame; forced-low data reads all pressed
        do_reset();
        for (int i = 0; i < 5; i++)
            run_frame(1, $urandom, 1'b0, $sformatf("t4_rnd%0d", i), cyc);
        run_frame(1, $urandom, 1'b1, "t4_forced", cyc);
        check("t4_forced_j1", 32'(j1[1]), 32'h0000_FFFF);
        check("t4_forced_j2", 32'(j2[1]), 32'h0000_FFFF);
        run_frame(1, 32'h0, 1'b0, "t4_release", cyc);

        // 6: fast divider, frame period and sample point
        do_reset();
        run_frame(2, 32'h0, 1'b0, "t6_first", cyc);
        check("t6_first_cycle", 32'(cyc), 32'd134);
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            run_frame(2, rnd, 1'b0, $sformatf("t6_a%0d", i), cyc);
            check($sformatf("t6_period_a%0d", i), 32'(cyc), 32'd134);
            run_frame(2, rnd, 1'b0, $sformatf("t6_b%0d", i), cyc);
            check($sformatf("t6_period_b%0d", i), 32'(cyc), 32'd134);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
